// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction fields, flush request and the hazard/forwarding
// controls returned to the pipeline.
interface fwd_hazard_ctrl_if #(
  parameter int REG_W = 6
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_wr;
  logic             id_load;
  logic             flush;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             stall;
  logic             bubble;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr, id_load, flush,
    input  fwd_a_sel, fwd_b_sel, stall, bubble
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_wr, id_load, flush,
    output fwd_a_sel, fwd_b_sel, stall, bubble
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: shadows the EX/MEM/WB
// destinations and drives the EX operand mux selects, stall and bubble.
module fwd_hazard_ctrl #(
  parameter int REG_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  fwd_hazard_ctrl_if.slave   bus
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             load;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             use_rs;
    logic             use_rt;
  } ex_entry_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             load;
  } mem_entry_t;

  // A WB value is always forwardable, so the load flag is not carried here.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
  } wb_entry_t;

  ex_entry_t  ex_reg,  ex_next;
  mem_entry_t mem_reg, mem_next;
  wb_entry_t  wb_reg,  wb_next;

  logic rs_hit;
  logic rt_hit;
  logic load_use;
  logic stall_int;

  always_comb begin
    rs_hit    = bus.id_use_rs && (bus.id_rs == ex_reg.rd);
    rt_hit    = bus.id_use_rt && (bus.id_rt == ex_reg.rd);
    load_use  = bus.id_valid && ex_reg.valid && ex_reg.wr && ex_reg.load && (rs_hit || rt_hit);
    stall_int = load_use && !bus.flush;
  end

  assign bus.stall  = stall_int;
  assign bus.bubble = stall_int || bus.flush;

  always_comb begin
    ex_next        = '0;
    ex_next.valid  = bus.id_valid;
    ex_next.rd     = bus.id_rd;
    ex_next.wr     = bus.id_wr;
    ex_next.load   = bus.id_load;
    ex_next.rs     = bus.id_rs;
    ex_next.rt     = bus.id_rt;
    ex_next.use_rs = bus.id_use_rs;
    ex_next.use_rt = bus.id_use_rt;

    mem_next.valid = ex_reg.valid;
    mem_next.rd    = ex_reg.rd;
    mem_next.wr    = ex_reg.wr;
    mem_next.load  = ex_reg.load;

    wb_next.valid  = mem_reg.valid;
    wb_next.rd     = mem_reg.rd;
    wb_next.wr     = mem_reg.wr;

    // Stall holds ID upstream and inserts a NOP; flush also kills the EX instruction.
    if (stall_int || bus.flush) begin
      ex_next = '0;
    end
    if (bus.flush) begin
      mem_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg  <= '0;
      mem_reg <= '0;
      wb_reg  <= '0;
    end else begin
      ex_reg  <= ex_next;
      mem_reg <= mem_next;
      wb_reg  <= wb_next;
    end
  end

  logic [REG_W-1:0] ex_src [2];
  logic             ex_use [2];

  assign ex_src[0] = ex_reg.rs;
  assign ex_src[1] = ex_reg.rt;
  assign ex_use[0] = ex_reg.use_rs;
  assign ex_use[1] = ex_reg.use_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [1:0] sel;

      // MEM holds the newer value, so it is checked first; a MEM load has no data yet.
      always_comb begin
        sel = 2'b00;
        if (ex_reg.valid && ex_use[gi]) begin
          if (mem_reg.valid && mem_reg.wr && !mem_reg.load && (mem_reg.rd == ex_src[gi])) begin
            sel = 2'b01;
          end else if (wb_reg.valid && wb_reg.wr && (wb_reg.rd == ex_src[gi])) begin
            sel = 2'b10;
          end
        end
      end

      if (gi == 0) begin : g_a
        assign bus.fwd_a_sel = sel;
      end else begin : g_b
        assign bus.fwd_b_sel = sel;
      end
    end
  endgenerate

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed, table-driven bench for fwd_hazard_ctrl: each row is one ID-stage
// cycle with the outputs expected during that cycle.
module tb_fwd_hazard_ctrl;
  localparam int REG_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_W(REG_W)) bus ();
  fwd_hazard_ctrl #(.REG_W(REG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string name;
    bit    v;
    int    rs;
    bit    urs;
    int    rt;
    bit    urt;
    int    rd;
    bit    wr;
    bit    ld;
    bit    fl;
    bit    rs_t;
    bit    e_stall;
    bit    e_bubble;
    int    e_a;
    int    e_b;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(string n, bit v, int rs, bit urs, int rt, bit urt, int rd, bit wr,
                     bit ld, bit fl, bit r, bit es, bit eb, int ea, int eb2);
    vec_t x;
    x.name = n; x.v = v; x.rs = rs; x.urs = urs; x.rt = rt; x.urt = urt;
    x.rd = rd; x.wr = wr; x.ld = ld; x.fl = fl; x.rs_t = r;
    x.e_stall = es; x.e_bubble = eb; x.e_a = ea; x.e_b = eb2;
    vecs.push_back(x);
  endtask

  task automatic nop(string n);
    add(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive(bit v, int rs, bit urs, int rt, bit urt, int rd, bit wr, bit ld, bit fl);
    bus.id_valid  = v;
    bus.id_rs     = REG_W'(rs);
    bus.id_use_rs = urs;
    bus.id_rt     = REG_W'(rt);
    bus.id_use_rt = urt;
    bus.id_rd     = REG_W'(rd);
    bus.id_wr     = wr;
    bus.id_load   = ld;
    bus.flush     = fl;
  endtask

  task automatic check(string n, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;

    //   name          v rs urs rt urt rd wr ld fl rst  stl bub  a  b
    add("rst_idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0);
    add("rst_flush",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1,   0, 0);
    add("alu_add",     1, 1, 1, 2, 1, 5, 1, 0, 0, 0,   0, 0,   0, 0);
    add("alu_sub",     1, 5, 1, 6, 1, 8, 1, 0, 0, 0,   0, 0,   0, 0);
    add("alu_d2",      1, 5, 1, 0, 0, 9, 1, 0, 0, 0,   0, 0,   1, 0);
    add("alu_d3",      1, 5, 1, 0, 0,10, 1, 0, 0, 0,   0, 0,   2, 0);
    add("alu_d3_ex",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0);
    nop("drain");
    nop("drain");
    add("ld_r7",       1, 1, 1, 0, 0, 7, 1, 1, 0, 0,   0, 0,   0, 0);
    add("lu_stall",    1, 7, 1, 7, 1, 2, 1, 0, 0, 0,   1, 1,   0, 0);
    add("lu_retry",    1, 7, 1, 7, 1, 2, 1, 0, 0, 0,   0, 0,   0, 0);
    add("lu_fwd",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   2, 2);
    nop("drain");
    nop("drain");
    add("ld_r11",      1, 0, 0, 0, 0,11, 1, 1, 0, 0,   0, 0,   0, 0);
    add("ld_gap",      1, 1, 1, 0, 0,12, 1, 0, 0, 0,   0, 0,   0, 0);
    add("ld_d2_use",   1,11, 1, 0, 0,13, 1, 0, 0, 0,   0, 0,   0, 0);
    add("ld_d2_fwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   2, 0);
    nop("drain");
    nop("drain");
    add("w3_a",        1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   0, 0,   0, 0);
    add("w3_b",        1, 0, 0, 0, 0, 3, 1, 0, 0, 0,   0, 0,   0, 0);
    add("rd3",         1, 3, 1, 3, 1,14, 1, 0, 0, 0,   0, 0,   0, 0);
    add("dbl_newest",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   1, 1);
    nop("drain");
    nop("drain");
    add("w4",          1, 0, 0, 0, 0, 4, 1, 0, 0, 0,   0, 0,   0, 0);
    add("flush_rd4",   1, 4, 1, 0, 0,15, 1, 0, 1, 0,   0, 1,   0, 0);
    add("after_flush", 1, 4, 1, 0, 0,16, 1, 0, 0, 0,   0, 0,   0, 0);
    add("killed_fwd",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0);
    nop("drain");
    nop("drain");
    add("ld_r20",      1, 0, 0, 0, 0,20, 1, 1, 0, 0,   0, 0,   0, 0);
    add("flush_lu",    1,20, 1, 0, 0,21, 1, 0, 1, 0,   0, 1,   0, 0);
    add("post_flush",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0);
    add("w9_a",        1, 0, 0, 0, 0, 9, 1, 0, 0, 0,   0, 0,   0, 0);
    add("w9_b",        1, 0, 0, 0, 0, 9, 1, 0, 0, 0,   0, 0,   0, 0);
    add("rd9_rst",     1, 9, 1, 0, 0,22, 1, 0, 0, 1,   0, 0,   0, 0);
    add("rd9",         1, 9, 1, 0, 0,22, 1, 0, 0, 0,   0, 0,   0, 0);
    add("rd9_no_fwd",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 0);
    nop("drain");
    add("w23",         1, 0, 0, 0, 0,23, 1, 0, 0, 0,   0, 0,   0, 0);
    add("nouse_rs",    1,23, 0,23, 1,24, 1, 0, 0, 0,   0, 0,   0, 0);
    add("nouse_fwd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0,   0, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].rs, vecs[i].urs, vecs[i].rt, vecs[i].urt,
            vecs[i].rd, vecs[i].wr, vecs[i].ld, vecs[i].fl);
      rst = vecs[i].rs_t;
      #2;
      $display("row %0d %s: stall=%0b bubble=%0b a=%0d b=%0d", i, vecs[i].name,
               bus.stall, bus.bubble, bus.fwd_a_sel, bus.fwd_b_sel);
      check({vecs[i].name, ".stall"},  8'(bus.stall),     8'(vecs[i].e_stall));
      check({vecs[i].name, ".bubble"}, 8'(bus.bubble),    8'(vecs[i].e_bubble));
      check({vecs[i].name, ".a_sel"},  8'(bus.fwd_a_sel), 8'(vecs[i].e_a));
      check({vecs[i].name, ".b_sel"},  8'(bus.fwd_b_sel), 8'(vecs[i].e_b));
      step();
      rst = 1'b0;
    end

    // Reset landing on the stall edge must erase the load entirely.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    drive(1, 0, 0, 0, 0, 30, 1, 1, 0);
    step();
    drive(1, 30, 1, 0, 0, 31, 1, 0, 0);
    #2;
    $display("seq rst_mid_stall: stall=%0b bubble=%0b", bus.stall, bus.bubble);
    check("rstseq.stall_before", 8'(bus.stall), 8'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    $display("seq rst_retry: stall=%0b bubble=%0b", bus.stall, bus.bubble);
    check("rstseq.stall_after",  8'(bus.stall),  8'd0);
    check("rstseq.bubble_after", 8'(bus.bubble), 8'd0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    $display("seq rst_user_ex: a=%0d b=%0d", bus.fwd_a_sel, bus.fwd_b_sel);
    check("rstseq.a_sel", 8'(bus.fwd_a_sel), 8'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
